// File: rtl/pucch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pucch_pkg
//  Purpose  : Shared constants, state encoding and Gold-sequence LFSR step
//             helpers for the PUCCH format 2/3/4 bit scrambler.
//  Macro    : PUCCH_SCR_FASTWARM_EN - when defined, the warm-up phase
//             advances the LFSRs 8 steps per cycle (200 cycles) instead of
//             1 step per cycle (1600 cycles).
//  Revision : 1.0 - initial release
// ============================================================================
package pucch_pkg;

    // Gold sequence offset and LFSR length.
    localparam int NC       = 1600;
    localparam int GOLD_LEN = 31;

`ifdef PUCCH_SCR_FASTWARM_EN
    localparam int WARM_STEP = 8;
`else
    localparam int WARM_STEP = 1;
`endif

    // Warm-up cycle count and its terminal counter value.
    localparam int                WARM_CYCLES = NC / WARM_STEP;
    localparam int                WARM_CNT_W  = 11;
    localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(WARM_CYCLES - 1);

    // Step-count encodings fed to the Gold generator.
    localparam int                ADV_W    = 4;
    localparam logic [ADV_W-1:0]  ADV_NONE = 4'd0;
    localparam logic [ADV_W-1:0]  ADV_PAIR = 4'd2;
    localparam logic [ADV_W-1:0]  ADV_WARM = ADV_W'(WARM_STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } scr_state_t;

    // Register bit i holds x(n+i); one step shifts right and appends x(n+31).
    function automatic logic [GOLD_LEN-1:0] x1_adv(input logic [GOLD_LEN-1:0] x,
                                                   input logic [ADV_W-1:0]    n);
        logic [GOLD_LEN-1:0] r;
        r = x;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n)) begin
                r = {r[3] ^ r[0], r[GOLD_LEN-1:1]};
            end
        end
        return r;
    endfunction

    function automatic logic [GOLD_LEN-1:0] x2_adv(input logic [GOLD_LEN-1:0] x,
                                                   input logic [ADV_W-1:0]    n);
        logic [GOLD_LEN-1:0] r;
        r = x;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n)) begin
                r = {r[3] ^ r[2] ^ r[1] ^ r[0], r[GOLD_LEN-1:1]};
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gold_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : gold_seq_gen
//  Purpose  : x1/x2 LFSR pair producing the Gold sequence c(n), c(n+1).
//  Ports    : i_clk, i_rst      - clock, async active-high reset
//             i_load            - reload x1 = 1, x2 = i_c_init
//             i_c_init[30:0]    - scrambling seed
//             i_adv[3:0]        - LFSR steps this cycle (0, 2 or 8/1)
//             o_c0, o_c1        - c(n) and c(n+1) at the current position
//  Revision : 1.0 - initial release
// ============================================================================
module gold_seq_gen
    import pucch_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [GOLD_LEN-1:0] i_c_init,
    input  logic [ADV_W-1:0]    i_adv,
    output logic                o_c0,
    output logic                o_c1
);

    logic [GOLD_LEN-1:0] x1_q, x1_d;
    logic [GOLD_LEN-1:0] x2_q, x2_d;

    always_comb begin
        x1_d = x1_q;
        x2_d = x2_q;
        if (i_load) begin
            x1_d = {{(GOLD_LEN-1){1'b0}}, 1'b1};
            x2_d = i_c_init;
        end else begin
            x1_d = x1_adv(x1_q, i_adv);
            x2_d = x2_adv(x2_q, i_adv);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x1_q <= '0;
            x2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
        end
    end

    // After warm-up, bit 0 of each register is x(n+NC) for the current n.
    assign o_c0 = x1_q[0] ^ x2_q[0];
    assign o_c1 = x1_q[1] ^ x2_q[1];

endmodule
`default_nettype wire

// File: rtl/pucch_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : pucch_scrambler
//  Purpose  : Scrambles the PUCCH UCI bitstream two bits per beat with the
//             Gold sequence c(n) and feeds the QPSK mapper.
//  Ports    : i_clk, i_rst               - clock, async active-high reset
//             i_start, i_c_init,
//             i_num_pairs                - transmission setup (IDLE only)
//             i_b0b1, i_valid, o_ready   - input pair stream
//             o_b0b1, o_valid, i_ready   - scrambled output stream
//             o_busy, o_done             - transmission status
//  Macro    : PUCCH_SCR_FASTWARM_EN (see pucch_pkg) selects 8-step warm-up.
//  Revision : 1.0 - initial release
// ============================================================================
module pucch_scrambler
    import pucch_pkg::*;
#(
    parameter int LEN_W = 13
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [GOLD_LEN-1:0] i_c_init,
    input  logic [LEN_W-1:0]    i_num_pairs,
    input  logic [1:0]          i_b0b1,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [1:0]          o_b0b1,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_done
);

    scr_state_t             state_q, state_d;
    logic [WARM_CNT_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [LEN_W-1:0]       pair_cnt_q, pair_cnt_d;
    logic [LEN_W-1:0]       num_pairs_q, num_pairs_d;
    logic [1:0]             b0b1_q, b0b1_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   w_gen_load;
    logic [ADV_W-1:0]       w_gen_adv;
    logic                   w_c0, w_c1;
    logic                   w_in_hs, w_out_hs;
    logic [LEN_W-1:0]       w_pair_cnt_inc;

    gold_seq_gen u_gold (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_gen_load),
        .i_c_init (i_c_init),
        .i_adv    (w_gen_adv),
        .o_c0     (w_c0),
        .o_c1     (w_c1)
    );

    assign o_ready        = (state_q == S_RUN) && (!valid_q || i_ready);
    assign w_in_hs        = i_valid && o_ready;
    assign w_out_hs       = valid_q && i_ready;
    assign w_pair_cnt_inc = pair_cnt_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        pair_cnt_d  = pair_cnt_q;
        num_pairs_d = num_pairs_q;
        b0b1_d      = b0b1_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        w_gen_load  = 1'b0;
        w_gen_adv   = ADV_NONE;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_num_pairs == '0) begin
                        // Empty transmission: acknowledge without going busy.
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_WARMUP;
                        w_gen_load  = 1'b1;
                        warm_cnt_d  = '0;
                        pair_cnt_d  = '0;
                        num_pairs_d = i_num_pairs;
                        busy_d      = 1'b1;
                    end
                end
            end

            S_WARMUP: begin
                w_gen_adv  = ADV_WARM;
                warm_cnt_d = warm_cnt_q + WARM_CNT_W'(1);
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (w_out_hs) begin
                    valid_d = 1'b0;
                end
                // A new load overrides the clear from a same-cycle output handshake.
                if (w_in_hs) begin
                    b0b1_d     = {i_b0b1[1] ^ w_c1, i_b0b1[0] ^ w_c0};
                    valid_d    = 1'b1;
                    w_gen_adv  = ADV_PAIR;
                    pair_cnt_d = w_pair_cnt_inc;
                    if (w_pair_cnt_inc == num_pairs_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (w_out_hs || !valid_q) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            warm_cnt_q  <= '0;
            pair_cnt_q  <= '0;
            num_pairs_q <= '0;
            b0b1_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            pair_cnt_q  <= pair_cnt_d;
            num_pairs_q <= num_pairs_d;
            b0b1_q      <= b0b1_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_b0b1  = b0b1_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pucch_scrambler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pucch_scrambler
//  Purpose  : Directed self-checking bench for pucch_scrambler against an
//             array-based Gold sequence model.
//  Macro    : PUCCH_SCR_FASTWARM_EN selects the expected warm-up length.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pucch_scrambler;

    localparam int LEN_W = 13;
    localparam int NCM   = 1600;
`ifdef PUCCH_SCR_FASTWARM_EN
    localparam int EXP_WARM = 200;
`else
    localparam int EXP_WARM = 1600;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [30:0]       i_c_init;
    logic [LEN_W-1:0]  i_num_pairs;
    logic [1:0]        i_b0b1;
    logic              i_valid;
    logic              o_ready;
    logic [1:0]        o_b0b1;
    logic              o_valid;
    logic              i_ready;
    logic              o_busy;
    logic              o_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pucch_scrambler #(.LEN_W(LEN_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (i_start),
        .i_c_init    (i_c_init),
        .i_num_pairs (i_num_pairs),
        .i_b0b1      (i_b0b1),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_b0b1      (o_b0b1),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference Gold sequence built straight from the recurrences.
    bit       x1m [0:2047];
    bit       x2m [0:2047];
    bit       cseq[0:511];
    logic [1:0] din[0:255];

    task automatic gen_c(input logic [30:0] ci, input int nbits);
        for (int i = 0; i < 31; i++) begin
            x1m[i] = (i == 0);
            x2m[i] = ci[i];
        end
        for (int n = 0; n < NCM + nbits; n++) begin
            x1m[n+31] = x1m[n+3] ^ x1m[n];
            x2m[n+31] = x2m[n+3] ^ x2m[n+2] ^ x2m[n+1] ^ x2m[n];
        end
        for (int n = 0; n < nbits; n++) begin
            cseq[n] = x1m[n+NCM] ^ x2m[n+NCM];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_and_warm(input logic [30:0] ci, input int n);
        int w;
        i_c_init    = ci;
        i_num_pairs = LEN_W'(n);
        i_start     = 1'b1;
        i_ready     = 1'b1;
        i_valid     = 1'b0;
        step();
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        w = 0;
        while (!o_ready && w < 3000) begin
            step();
            w++;
        end
        check("warmup_cycles", 32'(w), 32'(EXP_WARM));
    endtask

    // Streams n pairs from din[]; abort_at >= 0 stops after that many inputs.
    task automatic stream(input logic [30:0] ci, input int n, input bit stall,
                          input bit mid_start, input int abort_at);
        int  sent, rcvd, cyc;
        bit  in_hs, out_hs;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < n && cyc < 5000) begin
            if (abort_at >= 0 && sent == abort_at) break;
            i_valid = (sent < n) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            i_b0b1  = (sent < n) ? din[sent] : 2'b00;
            i_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mid_start && cyc == 20) begin
                i_start     = 1'b1;
                i_c_init    = ~ci;
                i_num_pairs = LEN_W'(5);
            end
            #1;
            in_hs  = i_valid && o_ready;
            out_hs = o_valid && i_ready;
            if (out_hs) begin
                check("pair", 32'(o_b0b1),
                      32'(din[rcvd] ^ {cseq[2*rcvd+1], cseq[2*rcvd]}));
                rcvd++;
            end
            step();
            cyc++;
            i_start = 1'b0;
            if (in_hs) begin
                check("latency_valid", 32'(o_valid), 32'd1);
                sent++;
            end
        end
        i_valid = 1'b0;
        if (abort_at >= 0) begin
            check("abort_point", 32'(sent), 32'(abort_at));
        end else begin
            check("sent_count", 32'(sent), 32'(n));
            check("rcvd_count", 32'(rcvd), 32'(n));
            check("done_pulse", 32'(o_done), 32'd1);
            check("busy_clear", 32'(o_busy), 32'd0);
            check("valid_clear", 32'(o_valid), 32'd0);
            step();
            check("done_one_cycle", 32'(o_done), 32'd0);
        end
    endtask

    initial begin
        logic [30:0] ci;
        bit          seen;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_c_init    = '0;
        i_num_pairs = '0;
        i_b0b1      = 2'b00;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        step();
        step();
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_b0b1",  32'(o_b0b1),  32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        rst = 1'b0;
        step();

        // Zero seed, all-zero data: outputs are c(0..7) themselves.
        gen_c(31'd0, 8);
        for (int i = 0; i < 4; i++) din[i] = 2'b00;
        start_and_warm(31'd0, 4);
        stream(31'd0, 4, 1'b0, 1'b0, -1);

        // Random data with stalls on both sides.
        ci = 31'(32'h12345678 & 32'h7FFFFFFF);
        gen_c(ci, 200);
        for (int i = 0; i < 100; i++) din[i] = 2'($urandom_range(0, 3));
        start_and_warm(ci, 100);
        stream(ci, 100, 1'b1, 1'b0, -1);

        // Empty transmission.
        i_num_pairs = '0;
        i_c_init    = 31'h1;
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        check("zero_done", 32'(o_done), 32'd1);
        check("zero_busy", 32'(o_busy), 32'd0);
        seen = o_valid;
        step();
        check("zero_done_clear", 32'(o_done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            seen |= o_valid | o_busy;
            step();
        end
        check("zero_no_valid", 32'(seen), 32'd0);

        // Second start while running must be ignored.
        ci = 31'h05A5A5A5;
        gen_c(ci, 60);
        for (int i = 0; i < 30; i++) din[i] = 2'($urandom_range(0, 3));
        start_and_warm(ci, 30);
        stream(ci, 30, 1'b1, 1'b1, -1);

        // Reset mid-transmission, then restart from c(0).
        ci = 31'(32'h12345678 & 32'h7FFFFFFF);
        gen_c(ci, 200);
        for (int i = 0; i < 100; i++) din[i] = 2'($urandom_range(0, 3));
        start_and_warm(ci, 100);
        stream(ci, 100, 1'b1, 1'b0, 50);
        rst = 1'b1;
        #2;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_busy",  32'(o_busy),  32'd0);
        check("abort_ready", 32'(o_ready), 32'd0);
        step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= o_done;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        start_and_warm(ci, 100);
        stream(ci, 100, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pucch_scrambler.md
# pucch_scrambler

Bit-level scrambler for PUCCH formats 2/3/4. Accepts the encoded UCI bitstream two bits per beat and XORs each pair with the Gold sequence c(n) (TS 38.211 §5.2.1) seeded from a per-transmission c_init. Emits scrambled bit pairs b[2k], b[2k+1] directly into the QPSK mapper's 2-bit input. Sits between the rate-matching output and the QPSK mapper.

## Interface
- LEN_W, 13: width of pair count; max 2^LEN_W−1 pairs per transmission.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; loads i_c_init and i_num_pairs. Honoured only in IDLE.
- i_c_init  in  31  scrambling seed c_init.
- i_num_pairs  in  LEN_W  number of bit pairs to scramble.
- i_b0b1  in  2  input pair; bit[0]=b(2k), bit[1]=b(2k+1).
- i_valid  in  1  input pair valid.
- o_ready  out  1  block accepts input this cycle.
- o_b0b1  out  2  scrambled pair, same bit order, to QPSK mapper.
- o_valid  out  1  output pair valid.
- i_ready  in  1  downstream accepts output.
- o_busy  out  1  high from accepted i_start until o_done.
- o_done  out  1  one-cycle pulse after the last pair leaves the output.

## Operation
- x1 init: x1(0)=1, x1(1..30)=0. x2 init: x2(i)=c_init[i]. x1(n+31)=x1(n+3)^x1(n); x2(n+31)=x2(n+3)^x2(n+2)^x2(n+1)^x2(n); c(n)=x1(n+1600)^x2(n+1600).
- States: IDLE → (i_start, num_pairs≠0) WARMUP → (1600 LFSR steps done) RUN → (last pair accepted) DRAIN → (output register empty) IDLE.
- i_start with i_num_pairs=0: IDLE → IDLE, o_done pulses next cycle, o_busy never rises.
- WARMUP: LFSRs advance without output; o_ready=0.
- RUN: o_ready = !o_valid | i_ready. Input handshake (i_valid & o_ready): o_b0b1 ← {b1^c(2k+1), b0^c(2k)}; LFSRs advance exactly 2 steps; pair counter increments.
- LFSRs advance only on an input handshake; stalls on either side freeze c(n).
- Output handshake (o_valid & i_ready) clears o_valid unless a new pair loads in the same cycle.
- i_start while busy: ignored, no state change.
- i_rst asserted mid-transmission: all state discarded; block returns to IDLE; no o_done.

## Timing
- Reset values: o_ready=0, o_b0b1=0, o_valid=0, o_busy=0, o_done=0; state IDLE; LFSRs zero.
- Warm-up: 1600 cycles (default) from the cycle after i_start to first o_ready=1.
- Latency: input handshake at cycle t → o_valid at t+1.
- Throughput: 1 pair/cycle sustained with i_valid=i_ready=1.
- o_done: asserted the cycle after the final output handshake.

## Configuration
- PUCCH_SCR_FASTWARM_EN defined: WARMUP advances 8 LFSR steps per cycle; warm-up takes 200 cycles. RUN behaviour is unchanged.
- Undefined: WARMUP advances 1 step per cycle; warm-up takes 1600 cycles.
- Output sequences are identical in both builds.

## Structure
- Shared package pucch_pkg: NC=1600, GOLD_LEN=31, warm-up step constant, state enum scr_state_t.
- Sub-module gold_seq_gen contains the x1/x2 LFSRs. Ports: load, c_init, adv (step count 0/2/8), and outputs c(n), c(n+1).
- pucch_scrambler contains the FSM, pair counter and output register.

## Test plan
- c_init=0, 4 pairs of all-zero input, i_ready=1: o_ready rises at start+1601; outputs equal the golden model's c(0..7); o_done at last output+1.
- c_init=0x12345678 & 0x7FFFFFFF, 100 random pairs, random i_valid/i_ready stalls: output stream is bit-exact to the model; no pair dropped or duplicated.
- i_num_pairs=0 → o_done one cycle after i_start; o_valid never asserted.
- Second i_start during RUN → ignored; pair count and sequence unaffected.
- i_rst at pair 50 of 100, then a new start with the same c_init: sequence restarts from c(0).
- Build with PUCCH_SCR_FASTWARM_EN: first o_ready at start+201; output identical to the default build.
